flash_host_rd_adapter: RTL

Read-only host front end that sits directly upstream of the flash physical layer's host port. It accepts 32-bit byte-addressed read requests over a valid/ready interface and checks alignment and address window. Legal requests become word-address host reads to the phy. The block returns in-order responses, with error responses for illegal requests. It tracks outstanding reads and buffers returned data, because the phy's `host_req_done` cannot be back-pressured.

---
 rtl/flash_host_rd_adapter.sv | 114 +++++++++++
 1 files changed

// File: rtl/flash_host_rd_adapter.sv
// Read-only host front end for the flash phy: checks alignment and address window,
// issues word-address reads, and returns in-order responses from registered order/data FIFOs.
module flash_host_rd_adapter #(
  parameter int          NumBanks     = 2,
  parameter int          PagesPerBank = 256,
  parameter int          WordsPerPage = 256,
  parameter int          DataWidth    = 32,
  parameter int          Depth        = 2,
  parameter logic [31:0] BaseAddr     = 32'h2000_0000,
  localparam int         AddrW        = $clog2(NumBanks) + $clog2(PagesPerBank) + $clog2(WordsPerPage)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 host_req_o,
  output logic [AddrW-1:0]     host_addr_o,
  input  logic                 host_req_rdy_i,
  input  logic                 host_req_done_i,
  input  logic [DataWidth-1:0] host_rdata_i
);

  localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int              CntW    = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  logic                 legal, credit, accept, rsp_fire, head_err, d_pop;
  logic [PtrW-1:0]      owp_q, owp_d, orp_q, orp_d, dwp_q, dwp_d, drp_q, drp_d;
  logic [CntW-1:0]      ocnt_q, ocnt_d, dcnt_q, dcnt_d;
  logic [Depth-1:0]     order_vec;
  logic [DataWidth-1:0] data_rd [Depth];

  assign legal       = (req_addr_i[1:0] == 2'b00) &&
                       (req_addr_i[31:AddrW+2] == BaseAddr[31:AddrW+2]);
  // Credit looks only at the registered count, so rsp_ready_i never reaches req_ready_o.
  assign credit      = (ocnt_q < DepthC);
  assign host_req_o  = rst_ni & req_valid_i & legal & credit;
  assign req_ready_o = rst_ni & credit & (~legal | host_req_rdy_i);
  assign host_addr_o = req_addr_i[AddrW+1:2];
  assign accept      = req_valid_i & req_ready_o;

  assign head_err    = order_vec[orp_q];
  assign rsp_valid_o = (ocnt_q != '0) & (head_err | (dcnt_q != '0));
  assign rsp_err_o   = (ocnt_q != '0) & head_err;
  assign rsp_data_o  = (rsp_valid_o & ~head_err) ? data_rd[drp_q] : '0;
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;
  assign d_pop       = rsp_fire & ~head_err;

  always_comb begin
    owp_d  = owp_q;
    orp_d  = orp_q;
    dwp_d  = dwp_q;
    drp_d  = drp_q;
    ocnt_d = ocnt_q;
    dcnt_d = dcnt_q;
    if (accept)          owp_d = ptr_inc(owp_q);
    if (rsp_fire)        orp_d = ptr_inc(orp_q);
    if (host_req_done_i) dwp_d = ptr_inc(dwp_q);
    if (d_pop)           drp_d = ptr_inc(drp_q);
    case ({accept, rsp_fire})
      2'b10:   ocnt_d = ocnt_q + 1'b1;
      2'b01:   ocnt_d = ocnt_q - 1'b1;
      default: ocnt_d = ocnt_q;
    endcase
    case ({host_req_done_i, d_pop})
      2'b10:   dcnt_d = dcnt_q + 1'b1;
      2'b01:   dcnt_d = dcnt_q - 1'b1;
      default: dcnt_d = dcnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owp_q  <= '0;
      orp_q  <= '0;
      dwp_q  <= '0;
      drp_q  <= '0;
      ocnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      owp_q  <= owp_d;
      orp_q  <= orp_d;
      dwp_q  <= dwp_d;
      drp_q  <= drp_d;
      ocnt_q <= ocnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Entry storage is never reset; the counts alone decide which entries are live.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    logic                 err_q;
    logic [DataWidth-1:0] dat_q;

    always_ff @(posedge clk_i) begin
      if (accept && (owp_q == PtrW'(gi))) err_q <= ~legal;
      if (rst_ni && host_req_done_i && (dwp_q == PtrW'(gi))) dat_q <= host_rdata_i;
    end

    assign order_vec[gi] = err_q;
    assign data_rd[gi]   = dat_q;
  end

endmodule
